// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I multi-port register file
// and its busy scoreboard.
package rv32i_pkg;

  localparam int XLEN           = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_WAIT   = 2'd1,
    DBG_ACCESS = 2'd2,
    DBG_ACK    = 2'd3
  } rf_dbg_state_e;

endpackage

// File: rtl/rv32i_rf_scoreboard.sv
// Per-register busy scoreboard: decode marks destinations busy, writeback
// clears them; a same-cycle set beats a clear (the set is the newer producer).
module rv32i_rf_scoreboard
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sb_set,
  input  logic [AW-1:0]                sb_addr,
  input  logic [NUM_WR_PORTS-1:0]      wr_en,
  input  logic [NUM_WR_PORTS-1:0]      wr_clr,
  input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  output logic [NUM_RD_PORTS-1:0]      rd_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en[p] && wr_clr[p]) busy_next[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (sb_set) busy_next[sb_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Lookup uses stored bits only; a same-cycle set/clear shows up next cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// Multi-port RV32I integer register file with busy scoreboard and an arbitrated
// debug access port. Define RV32I_RF_BYPASS_EN for same-cycle write-to-read bypass.
module rv32i_regfile_mp #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD_PORTS*AW-1:0]     rd_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]        rd_busy,
  input  logic [NUM_WR_PORTS-1:0]        wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]     wr_addr,
  input  logic [NUM_WR_PORTS*XLEN-1:0]   wr_data,
  input  logic [NUM_WR_PORTS-1:0]        wr_clr,
  input  logic                           sb_set,
  input  logic [AW-1:0]                  sb_addr,
  input  logic                           dbg_req,
  input  logic                           dbg_we,
  input  logic [AW-1:0]                  dbg_addr,
  input  logic [XLEN-1:0]                dbg_wdata,
  output logic                           dbg_gnt,
  output logic [XLEN-1:0]                dbg_rdata,
  output logic                           dbg_stall
);
  import rv32i_pkg::*;

  logic [XLEN-1:0] regs [NUM_REGS];

  rf_dbg_state_e   state;
  rf_dbg_state_e   state_next;
  logic            rearm;
  logic            dbg_we_q;
  logic [AW-1:0]   dbg_addr_q;
  logic [XLEN-1:0] dbg_wdata_q;
  logic            dbg_wr;

  always_comb begin
    state_next = state;
    case (state)
      DBG_IDLE:   if (dbg_req && !rearm) state_next = DBG_WAIT;
      DBG_WAIT:   if (wr_en == '0)       state_next = DBG_ACCESS;
      DBG_ACCESS:                        state_next = DBG_ACK;
      DBG_ACK:                           state_next = DBG_IDLE;
      default:                           state_next = DBG_IDLE;
    endcase
  end

  // rearm blocks a held request from re-triggering until it is seen low in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DBG_IDLE;
      rearm <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DBG_ACK)                rearm <= 1'b1;
      else if (state == DBG_IDLE && !dbg_req) rearm <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == DBG_IDLE && state_next == DBG_WAIT) begin
      dbg_we_q    <= dbg_we;
      dbg_addr_q  <= dbg_addr;
      dbg_wdata_q <= dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
    end else if (state == DBG_ACCESS) begin
      dbg_rdata <= (dbg_addr_q == '0) ? '0 : regs[dbg_addr_q];
    end
  end

  assign dbg_gnt   = (state == DBG_ACK);
  assign dbg_stall = (state == DBG_WAIT) || (state == DBG_ACCESS);
  assign dbg_wr    = (state == DBG_ACCESS) && dbg_we_q && (dbg_addr_q != '0);

  // Later assignments win: debug first, then core ports from highest to port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (dbg_wr) regs[dbg_addr_q] <= dbg_wdata_q;
      for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != '0)
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
`ifdef RV32I_RF_BYPASS_EN
      for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])
          rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
      end
`endif
      if (rd_addr[i*AW +: AW] == '0) rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  rv32i_rf_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .AW           (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .wr_en   (wr_en),
    .wr_clr  (wr_clr),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Bench for rv32i_regfile_mp: two read and two write ports, directed steps
// plus randomized traffic against a behavioural register/busy model.
module tb_rv32i_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_stall;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  rv32i_regfile_mp #(
    .XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_stall(dbg_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
`ifdef RV32I_RF_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == a) return wr_data[p*32 +: 32];
`endif
    return m_regs[a];
  endfunction

  // Register r takes the value of the lowest-numbered enabled port aimed at it;
  // busy[r] is 1 if set this cycle, else 0 if cleared, else unchanged.
  task automatic model_update();
    logic [31:0] nxt [32];
    for (int r = 1; r < 32; r++) begin
      bit hit_set, hit_clr, written;
      nxt[r] = m_regs[r];
      written = 0;
      hit_clr = 0;
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == r) begin
          if (!written) nxt[r] = wr_data[p*32 +: 32];
          written = 1;
          if (wr_clr[p]) hit_clr = 1;
        end
      end
      hit_set = sb_set && int'(sb_addr) == r;
      if (hit_set)      m_busy[r] = 1'b1;
      else if (hit_clr) m_busy[r] = 1'b0;
    end
    for (int r = 1; r < 32; r++) m_regs[r] = nxt[r];
  endtask

  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      int a;
      a = int'(rd_addr[i*5 +: 5]);
      check($sformatf("rd%0d_data@x%0d", i, a), rd_data[i*32 +: 32], exp_read(a));
      check($sformatf("rd%0d_busy@x%0d", i, a), {31'b0, rd_busy[i]}, {31'b0, m_busy[a]});
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    sb_set = 1'b0; sb_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    model_reset();

    #3;
    check("rst_gnt", {31'b0, dbg_gnt}, 32'h0);
    check("rst_stall", {31'b0, dbg_stall}, 32'h0);
    check("rst_rdata", dbg_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      cycle();
    end

    // x5 write then read back; x0 write ignored
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd5, 5'd5};
    cycle();
    wr_en = 2'b00;
    check("x5_readback", rd_data[31:0], 32'hDEADBEEF);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF}; rd_addr = {5'd5, 5'd0};
    cycle();
    wr_en = 2'b00;
    check("x0_zero", rd_data[31:0], 32'h0);

    // dual write to x7: port 0 wins
    wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'hCAFE0007, 32'h0}; rd_addr = {5'd7, 5'd7};
    cycle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
    #1;
`ifdef RV32I_RF_BYPASS_EN
    check("x7_same_cycle", rd_data[31:0], 32'h11111111);
`else
    check("x7_same_cycle", rd_data[31:0], 32'hCAFE0007);
`endif
    cycle();
    wr_en = 2'b00;
    check("x7_port0_wins", rd_data[31:0], 32'h11111111);

    // scoreboard set beats same-cycle clear
    sb_set = 1'b1; sb_addr = 5'd3; rd_addr = {5'd3, 5'd3};
    cycle();
    wr_en = 2'b01; wr_clr = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
    cycle();
    sb_set = 1'b0; wr_en = 2'b00; wr_clr = 2'b00;
    check("x3_busy_set_wins", {31'b0, rd_busy[0]}, 32'h1);
    wr_en = 2'b01; wr_clr = 2'b01; wr_addr = {5'd0, 5'd3};
    cycle();
    wr_en = 2'b00; wr_clr = 2'b00;
    check("x3_busy_cleared", {31'b0, rd_busy[0]}, 32'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      wr_en   = 2'($urandom_range(0, 3));
      wr_clr  = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {32'($urandom), 32'($urandom)};
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = 5'($urandom_range(0, 7));
      rd_addr = (n % 4 == 0) ? 10'($urandom) : {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cycle();
    end
    wr_en = '0; wr_clr = '0; sb_set = 1'b0;

    // debug write of x9 against four cycles of core writes
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hA5A5A5A5};
    cycle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h12345678;
    wr_addr = {5'd0, 5'd10}; rd_addr = {5'd9, 5'd10};
    for (int k = 0; k < 4; k++) begin
      wr_data = {32'h0, 32'h10000000 + 32'(k)};
      cycle();
      check("dbg_stall_wait", {31'b0, dbg_stall}, 32'h1);
      check("dbg_gnt_wait", {31'b0, dbg_gnt}, 32'h0);
    end
    wr_en = 2'b00;
    cycle();
    check("dbg_stall_access", {31'b0, dbg_stall}, 32'h1);
    check("dbg_gnt_access", {31'b0, dbg_gnt}, 32'h0);
    cycle();
    check("dbg_gnt_ack", {31'b0, dbg_gnt}, 32'h1);
    check("dbg_stall_ack", {31'b0, dbg_stall}, 32'h0);
    check("dbg_rdata_old", dbg_rdata, 32'hA5A5A5A5);
    m_regs[9] = 32'h12345678;
    dbg_we = 1'b0;
    cycle();
    check("dbg_gnt_single", {31'b0, dbg_gnt}, 32'h0);
    cycle();
    check("dbg_no_rearm", {31'b0, dbg_stall}, 32'h0);
    dbg_req = 1'b0;
    cycle();
    check("x9_after_dbg", rd_data[63:32], 32'h12345678);

    // reset during WAIT aborts the access
    wr_en = 2'b01; wr_addr = {5'd0, 5'd11}; wr_data = {32'h0, 32'h0BADF00D}; rd_addr = {5'd11, 5'd11};
    cycle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'hFFFFFFFF;
    wr_addr = {5'd0, 5'd12};
    cycle();
    check("abort_in_wait", {31'b0, dbg_stall}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_stall", {31'b0, dbg_stall}, 32'h0);
    check("abort_gnt", {31'b0, dbg_gnt}, 32'h0);
    model_reset();
    dbg_req = 1'b0; dbg_we = 1'b0; wr_en = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("abort_no_gnt", {31'b0, dbg_gnt}, 32'h0);
    end
    check("abort_x11", rd_data[31:0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
